// File: rtl/fp_pkg.sv
// Shared FP32 definitions: field layout, bias, integer limits, flag indices
// and the converter state encoding.
package fp_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned INT_W     = 32;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned UE_W      = EXP_W + 1;   // signed unbiased exponent
    localparam int unsigned SIGN_POS  = 31;
    localparam int unsigned EXP_LSB   = 23;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXP_MAX   = 255;

    localparam logic [INT_W-1:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT32_MIN = 32'h8000_0000;

    localparam int unsigned FLAG_W        = 3;
    localparam int unsigned FLAG_INVALID  = 2;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_INEXACT  = 0;

    // Shift count: at most |0-23| = 23
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SHIFT,
        PACK,
        DONE
    } state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 field split and classification.
// Ports:
//   i_data        FP32 word
//   o_sign_c      sign bit
//   o_exp_c       biased exponent
//   o_frac_c      fraction field
//   o_is_nan_c    exponent all ones, fraction nonzero
//   o_is_inf_c    exponent all ones, fraction zero
//   o_is_zero_c   exponent and fraction zero (either sign)
//   o_is_denorm_c exponent zero, fraction nonzero
//   o_unb_exp_c   exponent minus bias, signed
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [FP_W-1:0]          i_data,
    output logic                     o_sign_c,
    output logic [EXP_W-1:0]         o_exp_c,
    output logic [FRAC_W-1:0]        o_frac_c,
    output logic                     o_is_nan_c,
    output logic                     o_is_inf_c,
    output logic                     o_is_zero_c,
    output logic                     o_is_denorm_c,
    output logic signed [UE_W-1:0]   o_unb_exp_c
);

    logic w_exp_max;
    logic w_exp_zero;
    logic w_frac_zero;

    // Field split and classification
    always_comb begin
        o_sign_c      = i_data[SIGN_POS];
        o_exp_c       = i_data[EXP_LSB +: EXP_W];
        o_frac_c      = i_data[FRAC_W-1:0];
        w_exp_max     = (o_exp_c == EXP_W'(EXP_MAX));
        w_exp_zero    = (o_exp_c == '0);
        w_frac_zero   = (o_frac_c == '0);
        o_is_nan_c    = w_exp_max && !w_frac_zero;
        o_is_inf_c    = w_exp_max && w_frac_zero;
        o_is_zero_c   = w_exp_zero && w_frac_zero;
        o_is_denorm_c = w_exp_zero && !w_frac_zero;
        o_unb_exp_c   = signed'(UE_W'({1'b0, o_exp_c}) - UE_W'(BIAS));
    end

endmodule

// File: rtl/fp32_to_int_seq.sv
// Multi-cycle FP32 -> signed int32 converter, round toward zero, saturating.
// The mantissa is walked into place SHIFT_STEP bits per cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake (ready only in IDLE)
//   in_data             FP32 operand
//   out_valid/out_ready output handshake
//   out_data            two's-complement result
//   out_flags           {invalid, overflow, inexact}
module fp32_to_int_seq
    import fp_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FP_W-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_W-1:0]     out_data,
    output logic [FLAG_W-1:0]    out_flags
);

    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8)) begin : g_step_chk
        $error("SHIFT_STEP must be 1, 2, 4 or 8");
    end

    localparam logic [CNT_W-1:0]        STEP     = CNT_W'(SHIFT_STEP);
    localparam logic signed [UE_W-1:0]  E_FRAC   = UE_W'(FRAC_W);
    localparam logic signed [UE_W-1:0]  E_SAT    = UE_W'(INT_W - 1);
    localparam logic [EXP_W-1:0]        EXP_MINF = EXP_W'(BIAS + INT_W - 1);

    state_t                 r_state, w_state_nxt;
    logic [FP_W-1:0]        r_data,  w_data_nxt;
    logic [INT_W-1:0]       r_mag,   w_mag_nxt;
    logic                   r_neg,   w_neg_nxt;
    logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
    logic                   r_left,  w_left_nxt;
    logic                   r_sticky, w_sticky_nxt;
    logic [FLAG_W-1:0]      r_flags, w_flags_nxt;
    logic                   r_in_ready, w_in_ready_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic [INT_W-1:0]       r_out_data, w_out_data_nxt;
    logic [FLAG_W-1:0]      r_out_flags, w_out_flags_nxt;

    logic                   w_sign;
    logic [EXP_W-1:0]       w_exp;
    logic [FRAC_W-1:0]      w_frac;
    logic                   w_is_nan, w_is_inf, w_is_zero, w_is_denorm;
    logic signed [UE_W-1:0] w_unb;

    logic [CNT_W-1:0]       w_amt;
    logic [CNT_W-1:0]       w_cnt_dec;
    logic [INT_W-1:0]       w_mask;
    logic [UE_W-1:0]        w_kdiff;

    fp32_unpack u_unpack (
        .i_data        (r_data),
        .o_sign_c      (w_sign),
        .o_exp_c       (w_exp),
        .o_frac_c      (w_frac),
        .o_is_nan_c    (w_is_nan),
        .o_is_inf_c    (w_is_inf),
        .o_is_zero_c   (w_is_zero),
        .o_is_denorm_c (w_is_denorm),
        .o_unb_exp_c   (w_unb)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_mag_nxt       = r_mag;
        w_neg_nxt       = r_neg;
        w_cnt_nxt       = r_cnt;
        w_left_nxt      = r_left;
        w_sticky_nxt    = r_sticky;
        w_flags_nxt     = r_flags;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_flags_nxt = r_out_flags;

        w_amt     = (r_cnt < STEP) ? r_cnt : STEP;
        w_cnt_dec = r_cnt - w_amt;
        w_mask    = (INT_W'(1) << w_amt) - INT_W'(1);
        w_kdiff   = (w_unb >= E_FRAC) ? UE_W'(w_unb - E_FRAC) : UE_W'(E_FRAC - w_unb);

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_state_nxt = DECODE;
                end
            end

            DECODE: begin
                w_neg_nxt    = 1'b0;
                w_flags_nxt  = '0;
                w_sticky_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_left_nxt   = 1'b0;
                w_state_nxt  = PACK;
                if (w_is_nan) begin
                    w_mag_nxt                  = INT32_MIN;
                    w_flags_nxt[FLAG_INVALID]  = 1'b1;
                end else if (w_is_inf) begin
                    w_mag_nxt                  = w_sign ? INT32_MIN : INT32_MAX;
                    w_flags_nxt[FLAG_OVERFLOW] = 1'b1;
                end else if (w_is_zero || w_is_denorm || w_unb[UE_W-1]) begin
                    // |x| < 1 truncates to zero; only a true zero is exact
                    w_mag_nxt                 = '0;
                    w_flags_nxt[FLAG_INEXACT] = !w_is_zero;
                end else if (w_unb >= E_SAT) begin
                    // -2^31 is the one exactly representable value in this range
                    if (w_sign && (w_exp == EXP_MINF) && (w_frac == '0)) begin
                        w_mag_nxt = INT32_MIN;
                    end else begin
                        w_mag_nxt                  = w_sign ? INT32_MIN : INT32_MAX;
                        w_flags_nxt[FLAG_OVERFLOW] = 1'b1;
                    end
                end else begin
                    w_mag_nxt  = INT_W'({1'b1, w_frac});
                    w_neg_nxt  = w_sign;
                    w_left_nxt = (w_unb >= E_FRAC);
                    w_cnt_nxt  = CNT_W'(w_kdiff);
                    if (w_kdiff != '0) w_state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (r_left) begin
                    w_mag_nxt = r_mag << w_amt;
                end else begin
                    w_mag_nxt    = r_mag >> w_amt;
                    w_sticky_nxt = r_sticky | (|(r_mag & w_mask));
                end
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_dec == '0) w_state_nxt = PACK;
            end

            PACK: begin
                w_out_data_nxt  = r_neg ? (INT_W'(0) - r_mag) : r_mag;
                w_out_flags_nxt = r_flags | {{(FLAG_W-1){1'b0}}, r_sticky};
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase

        w_in_ready_nxt = (w_state_nxt == IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_left      <= 1'b0;
            r_sticky    <= 1'b0;
            r_flags     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flags <= '0;
        end else begin
            r_data      <= w_data_nxt;
            r_mag       <= w_mag_nxt;
            r_neg       <= w_neg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_left      <= w_left_nxt;
            r_sticky    <= w_sticky_nxt;
            r_flags     <= w_flags_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_flags <= w_out_flags_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Self-checking bench: two converters (SHIFT_STEP 1 and 8) share one stimulus
// port selected by 'sel'; the idle one keeps out_ready high.
module tb_fp32_to_int_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        sel;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic [2:0]  a_out_flags;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_out_data;
    logic [2:0]  b_out_flags;

    assign a_in_valid  = in_valid & ~sel;
    assign a_out_ready = out_ready | sel;
    assign b_in_valid  = in_valid & sel;
    assign b_out_ready = out_ready | ~sel;

    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_data;
    logic [2:0]  m_out_flags;
    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_data  = sel ? b_out_data  : a_out_data;
    assign m_out_flags = sel ? b_out_flags : a_out_flags;

    fp32_to_int_seq #(.SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_flags(a_out_flags)
    );

    fp32_to_int_seq #(.SHIFT_STEP(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_flags(b_out_flags)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: value = 1.frac * 2^E computed with wide integers, truncated,
    // then clamped to the int32 range.
    function automatic void model(input logic [31:0] x, input int step,
                                  output logic [31:0] r, output logic [2:0] f,
                                  output int lat);
        int                e;
        int                k;
        bit                s;
        longint unsigned   m;
        longint unsigned   mag;
        longint            v;
        s   = x[31];
        e   = int'(x[30:23]);
        m   = 64'(x[22:0]) | 64'h80_0000;
        f   = 3'b000;
        lat = 2;
        r   = 32'h0;
        if (e == 255) begin
            if (x[22:0] != 23'd0) begin r = 32'h8000_0000; f = 3'b100; end
            else begin r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; f = 3'b010; end
            return;
        end
        if (e == 0) begin
            f = (x[22:0] != 23'd0) ? 3'b001 : 3'b000;
            return;
        end
        e = e - 127;
        if (e < 0) begin f = 3'b001; return; end
        if (e <= 30) begin
            k   = (e >= 23) ? e - 23 : 23 - e;
            lat = (k == 0) ? 2 : (k + step - 1) / step + 2;
        end
        if (e > 40) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            f = 3'b010;
            return;
        end
        if (e >= 23) begin
            mag = m << (e - 23);
        end else begin
            mag = m >> (23 - e);
            if ((mag << (23 - e)) != m) f = 3'b001;
        end
        v = s ? -longint'(mag) : longint'(mag);
        if (v > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF; f = 3'b010;
        end else if (v < -64'sd2147483648) begin
            r = 32'h8000_0000; f = 3'b010;
        end else begin
            r = v[31:0];
        end
    endfunction

    // One full transaction on the selected converter; lat counts edges from accept to out_valid.
    task automatic convert(input logic [31:0] x, output logic [31:0] d,
                           output logic [2:0] f, output int lat);
        int w;
        w = 0;
        while (!m_in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", 32'(m_in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!m_out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        d = m_out_data;
        f = m_out_flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic [2:0]  flags;
        int          lat1;
        int          lat8;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [31:0] d;
        logic [2:0]  f;
        int          lat;
        logic [31:0] er;
        logic [2:0]  ef;
        int          el;
        logic [31:0] x;
        bit          seen;

        vt[0]  = '{32'h3F80_0000, 32'h0000_0001, 3'b000, 25, 5};
        vt[1]  = '{32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, 19, 5};
        vt[2]  = '{32'h4B00_0001, 32'h0080_0001, 3'b000,  2, 2};
        vt[3]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010,  2, 2};
        vt[4]  = '{32'hCF00_0000, 32'h8000_0000, 3'b000,  2, 2};
        vt[5]  = '{32'hFF80_0000, 32'h8000_0000, 3'b010,  2, 2};
        vt[6]  = '{32'h7FC0_0000, 32'h8000_0000, 3'b100,  2, 2};
        vt[7]  = '{32'h3F00_0000, 32'h0000_0000, 3'b001,  2, 2};
        vt[8]  = '{32'h8000_0000, 32'h0000_0000, 3'b000,  2, 2};
        vt[9]  = '{32'h0000_0001, 32'h0000_0000, 3'b001,  2, 2};
        vt[10] = '{32'h4040_0000, 32'h0000_0003, 3'b000, 24, 5};
        vt[11] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000,  9, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0;
        sel       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_in_ready",  32'(m_in_ready),  32'd1);
            chk("reset_out_valid", 32'(m_out_valid), 32'd0);
            chk("reset_out_data",  m_out_data,       32'd0);
            chk("reset_out_flags", 32'(m_out_flags), 32'd0);
        end

        // Directed vectors on both step sizes
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 12; i++) begin
                convert(vt[i].din, d, f, lat);
                chk($sformatf("vec%0d_s%0d_data", i, s), d, vt[i].dout);
                chk($sformatf("vec%0d_s%0d_flags", i, s), 32'(f), 32'(vt[i].flags));
                chk($sformatf("vec%0d_s%0d_lat", i, s), 32'(lat), 32'(s ? vt[i].lat8 : vt[i].lat1));
            end
        end

        // Backpressure: result held, in_ready low, stray in_valid ignored
        sel = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hC2F6_E979;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!m_out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_lat", 32'(lat), 32'd19);
        for (int c = 0; c < 5; c++) begin
            chk("bp_data",     m_out_data,        32'hFFFF_FF85);
            chk("bp_flags",    32'(m_out_flags),  32'd1);
            chk("bp_valid",    32'(m_out_valid),  32'd1);
            chk("bp_in_ready", 32'(m_in_ready),   32'd0);
            if (c == 1) begin in_valid = 1'b1; in_data = 32'h3F80_0000; end
            if (c == 2) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_in_ready_hs_cycle", 32'(m_in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_in_ready_after", 32'(m_in_ready),  32'd1);
        chk("bp_valid_after",    32'(m_out_valid), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (m_out_valid || !m_in_ready) seen = 1'b1;
        end
        chk("bp_stray_ignored", 32'(seen), 32'd0);

        // Reset in the middle of a SHIFT sequence
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mid_valid",    32'(m_out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(m_in_ready),  32'd1);
        chk("rst_mid_data",     m_out_data,       32'd0);
        chk("rst_mid_flags",    32'(m_out_flags), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rel_in_ready", 32'(m_in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (m_out_valid) seen = 1'b1;
        end
        chk("rst_no_output", 32'(seen), 32'd0);
        convert(32'h4040_0000, d, f, lat);
        chk("rst_after_data",  d,         32'h0000_0003);
        chk("rst_after_flags", 32'(f),    32'd0);
        chk("rst_after_lat",   32'(lat),  32'd24);

        // Random operands against the reference model
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 150; i++) begin
                x = $urandom;
                if (i % 2 == 1) x[30:23] = 8'($urandom_range(100, 165));
                model(x, s ? 8 : 1, er, ef, el);
                convert(x, d, f, lat);
                chk($sformatf("rnd_s%0d_data_%08h", s, x), d, er);
                chk($sformatf("rnd_s%0d_flags_%08h", s, x), 32'(f), 32'(ef));
                chk($sformatf("rnd_s%0d_lat_%08h", s, x), 32'(lat), 32'(el));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp32_to_int_seq.md
Name: fp32_to_int_seq

Overview:
- Multi-cycle IEEE 754 single-precision to signed 32-bit integer converter.
- Acts as the decoding end of the FP datapath: it takes packed FP32 words produced by the add/sub unit and returns two's-complement integers to the integer side.
- Rounds toward zero and saturates, with status flags.
- Iterative barrel-free shifter; valid/ready handshakes on both sides; one conversion in flight.

Parameters:
- SHIFT_STEP, 1, mantissa bits shifted per cycle in SHIFT state. Legal values: 1, 2, 4, 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_data  in  32  FP32 operand: sign [31], exponent [30:23], fraction [22:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  signed integer result.
- out_flags  out  3  [2] invalid (NaN), [1] overflow (saturated), [0] inexact (nonzero bits discarded).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_flags=0. All internal registers are cleared.
- Reset mid-operation aborts the conversion with no output.
- State machine: IDLE -> DECODE -> SHIFT -> PACK -> DONE -> IDLE. Special cases go DECODE -> PACK.
- IDLE: in_ready=1. When in_valid&&in_ready, capture in_data and go to DECODE.
- DECODE (1 cycle): unpack fields; E = exp - 127 (signed 9-bit); mag = {1, fraction} zero-extended to 32 bits. Classification:
  - exp==255, fraction!=0: result 32'h8000_0000, flags 3'b100.
  - exp==255, fraction==0 (±inf): +inf -> 32'h7FFF_FFFF, -inf -> 32'h8000_0000; flags 3'b010.
  - exp==0 or E<0 (zero, denormal, |x|<1): result 0; inexact=1 unless exp==0 and fraction==0.
  - E>=31: if sign=1, exp=158 and fraction=0, result 32'h8000_0000 with no flags. Otherwise saturate by sign; flags 3'b010.
  - 0<=E<=30: load shift count k = |E-23| and direction (left if E>=23). If k==0, skip to PACK.
- SHIFT: each cycle, shift mag by min(SHIFT_STEP, k_remaining) and decrement the count.
  - Right shifts OR every discarded bit into a sticky register; sticky drives inexact.
  - Left shifts never overflow (E<=30 guarantees mag < 2^31).
  - Leave SHIFT when the count reaches 0.
- PACK (1 cycle): out_data = sign ? -mag : mag (two's complement, 32-bit); set flags.
- DONE: out_valid=1; out_data and out_flags held stable while out_ready=0.
  - On out_valid&&out_ready, out_valid drops next cycle and the FSM returns to IDLE.
  - in_ready is not reasserted in the same cycle as the handshake; no bypass.
- Latency from the input-accept edge to out_valid rising: ceil(k/SHIFT_STEP)+2 cycles for the normal path; 2 cycles for special cases and k==0.
- in_data changing while the converter is busy is ignored. in_valid is not required to stay high.
- Negative zero yields 0 with no flags.

Decomposition:
- Package fp_pkg holds:
  - FP32 field widths and positions, BIAS=127, EXP_MAX=255.
  - INT32_MAX / INT32_MIN constants.
  - flag bit indices.
  - the state enum (IDLE, DECODE, SHIFT, PACK, DONE).
- One sub-module, fp32_unpack: combinational field split plus classification (is_nan, is_inf, is_zero, is_denorm, unbiased exponent). Shared with other FP blocks.
- The FSM, shifter and sticky logic stay in fp32_to_int_seq.

Test Plan:
- 0x3F800000 (1.0), SHIFT_STEP=1 -> out_data=0x00000001, flags 000, out_valid 25 cycles after accept. With SHIFT_STEP=8 -> same data, 5 cycles.
- 0xC2F6E979 (-123.456) -> 0xFFFFFF85 (-123), flags 001. Then 0x4B000001 (8388609.0) -> 0x00800001, flags 000 (k=0 path, latency 2).
- 0x4F000000 (2^31) -> 0x7FFFFFFF, flags 010. 0xCF000000 (-2^31) -> 0x80000000, flags 000. 0xFF800000 (-inf) -> 0x80000000, flags 010.
- 0x7FC00000 (NaN) -> 0x80000000, flags 100. 0x3F000000 (0.5) -> 0, flags 001. 0x80000000 (-0) -> 0, flags 000. 0x00000001 (denormal) -> 0, flags 001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data and out_flags stay stable; in_ready stays 0.
  - A new in_valid pulse during the stall is ignored.
  - After out_ready=1, in_ready returns the following cycle.
- Reset mid-SHIFT: drop rst_n during a 1.0 conversion.
  - Outputs clear asynchronously, no out_valid is produced, in_ready=1 after release.
  - A following 0x40400000 (3.0) converts to 0x00000003.
